// File: rtl/irq_sink_ctrl.sv
// rtl/irq_sink_ctrl.sv - interrupt sink: edge capture, fixed-priority arbitration, req/ack/EOI handshake
//
// Purpose:
//   Consumer end of the peripheral interrupt lines. Rising edges of level
//   sources are latched into a pending register. The lowest-index pending and
//   enabled source is presented to the CPU. The request is then walked through
//   the ack and EOI steps, and at the end the serviced source receives a
//   one-cycle clear pulse.
//
// Ports:
//   clk            clock
//   rst            asynchronous active-high reset
//   src_irq_i      level interrupt inputs, synchronous to clk
//   src_enable_i   per-source arbitration enable
//   src_clear_o    one-hot, one-cycle clear pulse to the serviced source
//   cpu_irq_o      interrupt request to the CPU
//   cpu_irq_id_o   ID of the requested or serviced source
//   cpu_ack_i      CPU accepts the request (only honoured in REQ)
//   cpu_eoi_i      CPU end-of-interrupt (only honoured in SERVICE)
//   pending_o      pending register
//   busy_o         high while a request is outstanding (REQ/SERVICE/CLEAR)
module irq_sink_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq_i,
  input  logic [NUM_SRC-1:0] src_enable_i,
  output logic [NUM_SRC-1:0] src_clear_o,
  output logic               cpu_irq_o,
  output logic [ID_W-1:0]    cpu_irq_id_o,
  input  logic               cpu_ack_i,
  input  logic               cpu_eoi_i,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE, S_CLEAR} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] src_prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] clear_q, clear_d;
  logic               cpu_irq_q, cpu_irq_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               busy_q, busy_d;
  // Low for the first clock after reset so that src_prev_q can resample the
  // live levels without treating sources held high through reset as new edges.
  logic               arm_q;

  logic [NUM_SRC-1:0] capture;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] ack_clr;
  logic [ID_W-1:0]    winner;

  assign capture = src_irq_i & ~src_prev_q & {NUM_SRC{arm_q}};
  assign cand    = pending_q & src_enable_i;

  // Lowest index wins: scan from the top so the last hit is the lowest index.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    cpu_irq_d = cpu_irq_q;
    id_d      = id_q;
    clear_d   = '0;
    ack_clr   = '0;
    case (state_q)
      S_IDLE: begin
        if (|cand) begin
          state_d   = S_REQ;
          cpu_irq_d = 1'b1;
          id_d      = winner;
        end
      end
      // Once raised, the request stays up until acked even if the source is
      // masked meanwhile; the ID was latched on entry.
      S_REQ: begin
        if (cpu_ack_i) begin
          state_d   = S_SERVICE;
          cpu_irq_d = 1'b0;
          ack_clr   = NUM_SRC'(1) << id_q;
        end
      end
      S_SERVICE: begin
        if (cpu_eoi_i) begin
          state_d = S_CLEAR;
          clear_d = NUM_SRC'(1) << id_q;
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A fresh edge in the same cycle as the ack clear keeps the bit pending.
    pending_d = (pending_q & ~ack_clr) | capture;
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_prev_q <= '0;
      pending_q  <= '0;
      clear_q    <= '0;
      cpu_irq_q  <= 1'b0;
      id_q       <= '0;
      busy_q     <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_prev_q <= src_irq_i;
      pending_q  <= pending_d;
      clear_q    <= clear_d;
      cpu_irq_q  <= cpu_irq_d;
      id_q       <= id_d;
      busy_q     <= busy_d;
      arm_q      <= 1'b1;
    end
  end

  assign src_clear_o  = clear_q;
  assign cpu_irq_o    = cpu_irq_q;
  assign cpu_irq_id_o = id_q;
  assign pending_o    = pending_q;
  assign busy_o       = busy_q;

endmodule
